// File: rtl/ascon_pkg.sv
// Shared Ascon types, FSM encoding and round-constant helpers.
// Used by ascon_round, ascon_finalization and ascon_initialization.
package ascon_pkg;

   localparam int unsigned LANE_W     = 64;
   localparam int unsigned NLANES     = 5;
   localparam int unsigned STATE_W    = LANE_W * NLANES;
   localparam int unsigned KEY_W      = 128;
   localparam int unsigned P12_ROUNDS = 12;

   // Five 64-bit lanes; x0 occupies the most significant bits.
   typedef struct packed {
      logic [LANE_W-1:0] x0;
      logic [LANE_W-1:0] x1;
      logic [LANE_W-1:0] x2;
      logic [LANE_W-1:0] x3;
      logic [LANE_W-1:0] x4;
   } ascon_state_t;

   typedef enum logic [1:0] {
      ASCON_128  = 2'd0,
      ASCON_128A = 2'd1
   } sel_type_e;

   // LOAD is the settle cycle between key injection and the first round.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      PERM = 2'd2,
      FIN  = 2'd3
   } fin_state_e;

   // Constant of p12 round i: high nibble 15-i, low nibble i.
   function automatic logic [7:0] round_const(input logic [3:0] i);
      return {4'(4'hF - i), i};
   endfunction

   function automatic logic [LANE_W-1:0] ror64(input logic [LANE_W-1:0] v,
                                               input int unsigned n);
      return (v >> n) | (v << (LANE_W - n));
   endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant add, 5-bit S-box layer, linear layer.
module ascon_round
   import ascon_pkg::*;
(
   input  logic [STATE_W-1:0] state_i,
   input  logic [7:0]         rc_i,
   output logic [STATE_W-1:0] state_o
);

   ascon_state_t s_in, s_out;
   logic [LANE_W-1:0] a0, a1, a2, a3, a4;
   logic [LANE_W-1:0] v0, v1, v2, v3, v4;
   logic [LANE_W-1:0] w0, w1, w2, w3, w4;

   assign s_in    = ascon_state_t'(state_i);
   assign state_o = STATE_W'(s_out);

   // Constant addition, bitsliced S-box, then per-lane rotation diffusion.
   always_comb begin
      a0 = s_in.x0 ^ s_in.x4;
      a1 = s_in.x1;
      a2 = s_in.x2 ^ {56'd0, rc_i} ^ s_in.x1;
      a3 = s_in.x3;
      a4 = s_in.x4 ^ s_in.x3;

      v0 = a0 ^ (~a1 & a2);
      v1 = a1 ^ (~a2 & a3);
      v2 = a2 ^ (~a3 & a4);
      v3 = a3 ^ (~a4 & a0);
      v4 = a4 ^ (~a0 & a1);

      w0 = v0 ^ v4;
      w1 = v1 ^ v0;
      w2 = ~v2;
      w3 = v3 ^ v2;
      w4 = v4;

      s_out.x0 = w0 ^ ror64(w0, 19) ^ ror64(w0, 28);
      s_out.x1 = w1 ^ ror64(w1, 61) ^ ror64(w1, 39);
      s_out.x2 = w2 ^ ror64(w2, 1)  ^ ror64(w2, 6);
      s_out.x3 = w3 ^ ror64(w3, 10) ^ ror64(w3, 17);
      s_out.x4 = w4 ^ ror64(w4, 7)  ^ ror64(w4, 41);
   end

endmodule

// File: rtl/ascon_finalization.sv
// Ascon finalization: key injection, NROUNDS-round permutation, tag extraction.
// Optional feature macro ASCON_TAG_VERIFY_EN adds exp_tag / tag_ok comparison.
module ascon_finalization
   import ascon_pkg::*;
#(
   parameter int unsigned NROUNDS = 12
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [1:0]   sel_type,
   input  logic [127:0] key,
   input  logic [63:0]  x0_in,
   input  logic [63:0]  x1_in,
   input  logic [63:0]  x2_in,
   input  logic [63:0]  x3_in,
   input  logic [63:0]  x4_in,
`ifdef ASCON_TAG_VERIFY_EN
   input  logic [127:0] exp_tag,
   output logic [0:0]   tag_ok,
`endif
   output logic [127:0] tag,
   output logic         busy,
   output logic         done,
   output logic         err
);

   localparam int unsigned RC_BASE  = P12_ROUNDS - NROUNDS;
   localparam logic [3:0]  LAST_RND = 4'(NROUNDS - 1);

   fin_state_e          fsm_q, fsm_d;
   ascon_state_t        state_q, state_d, round_out;
   logic [STATE_W-1:0]  round_out_w;
   logic [KEY_W-1:0]    key_q, key_d;
   logic [KEY_W-1:0]    tag_q, tag_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [3:0]          rc_idx_c;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                req_c, sel_legal_c, accept_c, reject_c;
`ifdef ASCON_TAG_VERIFY_EN
   logic [KEY_W-1:0]    exp_q, exp_d;
   logic                tag_ok_q, tag_ok_d;
`endif

   // Start qualification: IDLE only, never in the done cycle.
   assign req_c       = (fsm_q == IDLE) && start && !done_q;
   assign sel_legal_c = (sel_type == ASCON_128) || (sel_type == ASCON_128A);
   assign accept_c    = req_c && sel_legal_c;
   assign reject_c    = req_c && !sel_legal_c;
   assign rc_idx_c    = 4'(RC_BASE) + cnt_q;

   ascon_round u_round (
      .state_i (STATE_W'(state_q)),
      .rc_i    (round_const(rc_idx_c)),
      .state_o (round_out_w)
   );
   assign round_out = ascon_state_t'(round_out_w);

   // State register and datapath flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q    <= IDLE;
         state_q  <= '0;
         key_q    <= '0;
         tag_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
`ifdef ASCON_TAG_VERIFY_EN
         exp_q    <= '0;
         tag_ok_q <= 1'b0;
`endif
      end else begin
         fsm_q    <= fsm_d;
         state_q  <= state_d;
         key_q    <= key_d;
         tag_q    <= tag_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
`ifdef ASCON_TAG_VERIFY_EN
         exp_q    <= exp_d;
         tag_ok_q <= tag_ok_d;
`endif
      end
   end

   // Next-state logic.
   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         IDLE:    if (accept_c) fsm_d = LOAD;
         LOAD:    fsm_d = PERM;
         PERM:    if (cnt_q == LAST_RND) fsm_d = FIN;
         FIN:     fsm_d = IDLE;
         default: fsm_d = IDLE;
      endcase
   end

   // Output and datapath next values.
   always_comb begin
      state_d  = state_q;
      key_d    = key_q;
      tag_d    = tag_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      err_d    = reject_c;
      busy_d   = (fsm_d != IDLE);
`ifdef ASCON_TAG_VERIFY_EN
      exp_d    = exp_q;
      tag_ok_d = tag_ok_q;
`endif
      case (fsm_q)
         IDLE: begin
            if (accept_c) begin
               key_d   = key;
               cnt_d   = '0;
               state_d = '{x0: x0_in, x1: x1_in, x2: x2_in, x3: x3_in, x4: x4_in};
               if (sel_type == ASCON_128) begin
                  state_d.x1 = x1_in ^ key[127:64];
                  state_d.x2 = x2_in ^ key[63:0];
               end else begin
                  state_d.x2 = x2_in ^ key[127:64];
                  state_d.x3 = x3_in ^ key[63:0];
               end
`ifdef ASCON_TAG_VERIFY_EN
               exp_d    = exp_tag;
               tag_ok_d = 1'b0;
`endif
            end
         end
         LOAD: cnt_d = '0;
         PERM: begin
            state_d = round_out;
            if (cnt_q != LAST_RND) cnt_d = cnt_q + 4'd1;
         end
         FIN: begin
            tag_d  = {state_q.x3 ^ key_q[127:64], state_q.x4 ^ key_q[63:0]};
            done_d = 1'b1;
`ifdef ASCON_TAG_VERIFY_EN
            tag_ok_d = (tag_d == exp_q);
`endif
         end
         default: ;
      endcase
   end

   assign tag  = tag_q;
   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;
`ifdef ASCON_TAG_VERIFY_EN
   assign tag_ok = tag_ok_q;
`endif

endmodule

// File: tb/tb_ascon_finalization.sv
// Self-checking bench for ascon_finalization against a table-driven Ascon model.
module tb_ascon_finalization;

   localparam int NR = 12;

   typedef logic [4:0][63:0] st_t;

   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
   localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
   localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

   logic         clk = 1'b0;
   logic         rst_n, start;
   logic [1:0]   sel_type;
   logic [127:0] key, exp_tag, tag;
   logic [63:0]  x0_in, x1_in, x2_in, x3_in, x4_in;
   logic         busy, done, err;
`ifdef ASCON_TAG_VERIFY_EN
   logic [0:0]   tag_ok;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   ascon_finalization #(.NROUNDS(NR)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .sel_type (sel_type),
      .key      (key),
      .x0_in    (x0_in),
      .x1_in    (x1_in),
      .x2_in    (x2_in),
      .x3_in    (x3_in),
      .x4_in    (x4_in),
`ifdef ASCON_TAG_VERIFY_EN
      .exp_tag  (exp_tag),
      .tag_ok   (tag_ok),
`endif
      .tag      (tag),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   // ---------------- reference model ----------------
   function automatic logic [63:0] ror(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   // Last n rounds of p12, S-box applied column by column from the table.
   function automatic st_t m_perm(input st_t s_in, input int n);
      st_t s;
      logic [4:0] v, o;
      s = s_in;
      for (int r = 12 - n; r < 12; r++) begin
         s[2] = s[2] ^ 64'(((15 - r) << 4) | r);
         for (int b = 0; b < 64; b++) begin
            v = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
            o = SBOX[v];
            s[0][b] = o[4]; s[1][b] = o[3]; s[2][b] = o[2];
            s[3][b] = o[1]; s[4][b] = o[0];
         end
         for (int i = 0; i < 5; i++)
            s[i] = s[i] ^ ror(s[i], ROT_A[i]) ^ ror(s[i], ROT_B[i]);
      end
      return s;
   endfunction

   // State just before finalization for empty AD and empty plaintext.
   function automatic st_t m_pre(input int variant, input logic [127:0] k);
      st_t s;
      s[0] = (variant == 0) ? 64'h80400c0600000000 : 64'h80800c0800000000;
      s[1] = k[127:64];
      s[2] = k[63:0];
      s[3] = 64'h0001020304050607;
      s[4] = 64'h08090a0b0c0d0e0f;
      s = m_perm(s, 12);
      s[3] = s[3] ^ k[127:64];
      s[4] = s[4] ^ k[63:0];
      s[4] = s[4] ^ 64'd1;
      s[0] = s[0] ^ 64'h8000000000000000;
      return s;
   endfunction

   function automatic logic [127:0] m_tag(input st_t s_in, input int variant,
                                          input logic [127:0] k, input int n);
      st_t s;
      s = s_in;
      if (variant == 0) begin
         s[1] = s[1] ^ k[127:64]; s[2] = s[2] ^ k[63:0];
      end else begin
         s[2] = s[2] ^ k[127:64]; s[3] = s[3] ^ k[63:0];
      end
      s = m_perm(s, n);
      return {s[3] ^ k[127:64], s[4] ^ k[63:0]};
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
      end
   endtask

   task automatic drive(input st_t s);
      x0_in = s[0]; x1_in = s[1]; x2_in = s[2]; x3_in = s[3]; x4_in = s[4];
   endtask

   function automatic logic [63:0] r64();
      return {$urandom, $urandom};
   endfunction

   // One-cycle start pulse, scramble inputs mid-flight, wait (bounded) for done.
   task automatic run_op(input logic [1:0] sel, input logic [127:0] k, input st_t s,
                         input logic [127:0] et, output int lat, output logic dn_next);
      @(negedge clk);
      sel_type = sel; key = k; drive(s); exp_tag = et;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = -1;
      for (int e = 1; e <= 40; e++) begin
         if (e == 3) begin
            key = {r64(), r64()};
            x0_in = r64(); x1_in = r64(); x2_in = r64(); x3_in = r64(); x4_in = r64();
            exp_tag = {r64(), r64()};
         end
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            lat = e;
            break;
         end
      end
      @(posedge clk);
      @(negedge clk);
      dn_next = done;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      st_t          pre, s;
      logic [127:0] k, exp, last_exp;
      int           lat, ndone, nerr, variant;
      logic         dn2;

      rst_n = 1'b0; start = 1'b0; sel_type = 2'd0; key = '0; exp_tag = '0;
      x0_in = '0; x1_in = '0; x2_in = '0; x3_in = '0; x4_in = '0;

      // Reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_tag",  tag, 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_done", 128'(done), 128'd0);
      chk("rst_err",  128'(err),  128'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_tag", tag, 128'd0);

      // Ascon-128 known-answer
      k   = 128'h000102030405060708090A0B0C0D0E0F;
      pre = m_pre(0, k);
      run_op(2'd0, k, pre, 128'hE355159F292911F794CB1432A0103A8A, lat, dn2);
      chk("kat128_lat",   128'(lat), 128'd14);
      chk("kat128_tag",   tag, 128'hE355159F292911F794CB1432A0103A8A);
      chk("kat128_pulse", 128'(dn2), 128'd0);
      chk("kat128_busy",  128'(busy), 128'd0);
`ifdef ASCON_TAG_VERIFY_EN
      chk("kat128_tag_ok", 128'(tag_ok), 128'd1);
`endif

      // Ascon-128a against the model
      pre = m_pre(1, k);
      exp = m_tag(pre, 1, k, NR);
      run_op(2'd1, k, pre, exp, lat, dn2);
      chk("a128a_lat", 128'(lat), 128'd14);
      chk("a128a_tag", tag, exp);

      // Ascon-128a with corrupted x1: key must land on x2/x3 only
      s = pre;
      s[1] = s[1] ^ r64();
      exp = m_tag(s, 1, k, NR);
      run_op(2'd1, k, s, ~exp, lat, dn2);
      chk("a128a_x1corrupt_tag", tag, exp);
`ifdef ASCON_TAG_VERIFY_EN
      chk("a128a_x1corrupt_tag_ok", 128'(tag_ok), 128'd0);
`endif
      last_exp = exp;

      // Reserved sel_type values raise err, stay idle, keep tag
      for (int sv = 2; sv <= 3; sv++) begin
         @(negedge clk);
         sel_type = 2'(sv); key = k; start = 1'b1;
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         chk("err_pulse", 128'(err), 128'd1);
         chk("err_busy",  128'(busy), 128'd0);
         chk("err_tag",   tag, last_exp);
         @(posedge clk);
         @(negedge clk);
         chk("err_clear", 128'(err), 128'd0);
         chk("err_idle_busy", 128'(busy), 128'd0);
      end

      // Start held through busy and the done cycle: exactly one result
      pre = m_pre(0, k);
      @(negedge clk);
      sel_type = 2'd0; key = k; drive(pre); start = 1'b1;
      lat = -1; nerr = 0;
      for (int e = 0; e <= 40; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (err) nerr++;
         if (done) begin
            lat = e;
            break;
         end
      end
      chk("held_lat", 128'(lat), 128'd14);
      @(posedge clk);
      @(negedge clk);
      chk("held_done_cycle_ignored", 128'(busy), 128'd0);
      start = 1'b0;
      ndone = 0;
      for (int e = 0; e < 20; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) ndone++;
         if (err) nerr++;
      end
      chk("held_single_done", 128'(ndone), 128'd0);
      chk("held_no_err",      128'(nerr), 128'd0);
      chk("held_tag",         tag, 128'hE355159F292911F794CB1432A0103A8A);

      // Randomized operations against the model
      for (int it = 0; it < 6; it++) begin
         variant = int'($urandom_range(0, 1));
         k = {r64(), r64()};
         for (int i = 0; i < 5; i++) s[i] = r64();
         exp = m_tag(s, variant, k, NR);
         run_op(2'(variant), k, s, exp, lat, dn2);
         chk("rand_lat",   128'(lat), 128'd14);
         chk("rand_tag",   tag, exp);
         chk("rand_pulse", 128'(dn2), 128'd0);
`ifdef ASCON_TAG_VERIFY_EN
         chk("rand_tag_ok", 128'(tag_ok), 128'd1);
`endif
      end

      // Reset during PERM aborts the operation
      @(negedge clk);
      sel_type = 2'd0; key = k; drive(s); start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_tag",  tag, 128'd0);
      chk("midrst_busy", 128'(busy), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int e = 0; e < 20; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) ndone++;
      end
      chk("midrst_no_done", 128'(ndone), 128'd0);
      chk("midrst_tag_after", tag, 128'd0);

`ifdef ASCON_TAG_VERIFY_EN
      // Tag verify: exact match, then bit 0 flipped
      pre = m_pre(0, 128'h000102030405060708090A0B0C0D0E0F);
      exp = 128'hE355159F292911F794CB1432A0103A8A;
      run_op(2'd0, 128'h000102030405060708090A0B0C0D0E0F, pre, exp, lat, dn2);
      chk("verify_ok", 128'(tag_ok), 128'd1);
      run_op(2'd0, 128'h000102030405060708090A0B0C0D0E0F, pre, exp ^ 128'd1, lat, dn2);
      chk("verify_bad", 128'(tag_ok), 128'd0);
      chk("verify_bad_tag", tag, exp);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
